// File: rtl/caravel_ram_pkg.sv
// caravel_ram_pkg: definitions shared by the user-RAM Wishbone BIST.
//   state_t / S_*   : BIST controller state encoding
//   PAT_*           : pattern_sel encodings
//   LFSR_TAPS       : Galois LFSR feedback mask (right-shifting form)
//   RAM_WORDS       : number of 32-bit words in the 24 KB user RAM
//   RAM_ADDR_W      : word-index width
//   lfsr_next()     : one Galois LFSR step
package caravel_ram_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_WR_REQ = 3'd1;
  localparam state_t S_WR_GAP = 3'd2;
  localparam state_t S_RD_REQ = 3'd3;
  localparam state_t S_RD_GAP = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  localparam logic [1:0] PAT_IDX  = 2'd0;  // index xor seed
  localparam logic [1:0] PAT_SEED = 2'd1;  // constant seed
  localparam logic [1:0] PAT_LFSR = 2'd2;  // LFSR sequence
  localparam logic [1:0] PAT_ALT  = 2'd3;  // seed / ~seed alternating

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int unsigned RAM_WORDS  = 6144;
  localparam int unsigned RAM_ADDR_W = 13;

  // Shift right; when the bit shifted out is 1, fold in the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: word index and test-pattern source for the RAM BIST.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : latch pattern_sel/seed, idx = 0, LFSR = seed (0 -> 1)
//   rewind       : idx = 0, LFSR reloaded from the latched seed
//   advance      : idx + 1, LFSR one step
//   pattern_sel  : pattern select (captured on load)
//   seed         : pattern seed (captured on load)
//   idx          : current word index
//   pattern      : expected/write data for the current word
module bist_pattern_gen
  import caravel_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  rewind,
  input  logic [1:0]            pattern_sel,
  input  logic [31:0]           seed,
  output logic [RAM_ADDR_W-1:0] idx,
  output logic [31:0]           pattern
);

  logic [1:0]  sel_q;
  logic [31:0] seed_q;
  logic [31:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      seed_q <= '0;
      idx    <= '0;
      lfsr   <= '0;
    end else if (load) begin
      sel_q  <= pattern_sel;
      seed_q <= seed;
      idx    <= '0;
      lfsr   <= (seed == '0) ? 32'h1 : seed;
    end else if (rewind) begin
      idx    <= '0;
      lfsr   <= (seed_q == '0) ? 32'h1 : seed_q;
    end else if (advance) begin
      idx    <= idx + RAM_ADDR_W'(1);
      lfsr   <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    pattern = seed_q;
    case (sel_q)
      PAT_IDX:  pattern = {{(32-RAM_ADDR_W){1'b0}}, idx} ^ seed_q;
      PAT_SEED: pattern = seed_q;
      PAT_LFSR: pattern = lfsr;
      PAT_ALT:  pattern = idx[0] ? ~seed_q : seed_q;
      default:  pattern = seed_q;
    endcase
  end

endmodule

// File: rtl/caravel_ram_wb_bist.sv
// caravel_ram_wb_bist: Wishbone classic initiator that writes a pattern to
// every user-RAM word, reads it back and checks it.
//   wb_clk_i, wb_rst_ni          : clock, asynchronous active-low reset
//   start_i, pattern_sel_i, seed_i: test launch and pattern configuration
//   wbm_*                        : Wishbone master port to the RAM slave
//   busy_o, done_o, pass_o       : test status
//   timeout_o                    : a transfer was aborted for lack of ack
//   err_count_o                  : mismatch count (saturating)
//   fail_idx_o, fail_data_o      : index and read data of the first mismatch
module caravel_ram_wb_bist
  import caravel_ram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned WORDS     = RAM_WORDS,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            pattern_sel_i,
  input  logic [31:0]           seed_i,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [31:0]           wbm_dat_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [RAM_ADDR_W-1:0] fail_idx_o,
  output logic [31:0]           fail_data_o
);

  localparam int unsigned           TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RAM_ADDR_W-1:0] LAST_IDX = RAM_ADDR_W'(WORDS - 1);

  state_t                  state;
  logic [TW-1:0]           tcnt;
  logic [RAM_ADDR_W-1:0]   idx;
  logic [31:0]             pattern;
  logic                    start_ok;
  logic                    is_req;
  logic                    last;

  assign start_ok = ((state == S_IDLE) || (state == S_DONE)) && start_i;
  assign is_req   = (state == S_WR_REQ) || (state == S_RD_REQ);
  assign last     = (idx == LAST_IDX);

  bist_pattern_gen u_gen (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .load        (start_ok),
    .advance     (((state == S_WR_GAP) || (state == S_RD_GAP)) && !last),
    .rewind      ((state == S_WR_GAP) && last),
    .pattern_sel (pattern_sel_i),
    .seed        (seed_i),
    .idx         (idx),
    .pattern     (pattern)
  );

  // Bus controls decode straight from the state register so that an
  // asynchronous reset drops cyc/stb without waiting for a clock edge.
  assign wbm_cyc_o = is_req;
  assign wbm_stb_o = is_req;
  assign wbm_we_o  = (state == S_WR_REQ);
  assign wbm_sel_o = is_req ? 4'hF : 4'h0;
  assign wbm_adr_o = is_req ? ADDR_BASE + {{(30-RAM_ADDR_W){1'b0}}, idx, 2'b00} : '0;
  assign wbm_dat_o = (state == S_WR_REQ) ? pattern : '0;
  assign busy_o    = (state == S_WR_REQ) || (state == S_WR_GAP) ||
                     (state == S_RD_REQ) || (state == S_RD_GAP);
  assign done_o    = (state == S_DONE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_count_o <= '0;
      fail_idx_o  <= '0;
      fail_data_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state       <= S_WR_REQ;
            tcnt        <= '0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
            fail_idx_o  <= '0;
            fail_data_o <= '0;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (wbm_ack_i) begin
            if (state == S_RD_REQ && wbm_dat_i != pattern) begin
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
              if (err_count_o == '0) begin
                fail_idx_o  <= idx;
                fail_data_o <= wbm_dat_i;
              end
            end
            state <= (state == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
          end else if (tcnt == TO_LAST) begin
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WR_GAP: begin
          tcnt  <= '0;
          state <= last ? S_RD_REQ : S_WR_REQ;
        end
        S_RD_GAP: begin
          tcnt <= '0;
          if (last) begin
            state  <= S_DONE;
            pass_o <= (err_count_o == '0) && !timeout_o;
          end else begin
            state <= S_RD_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caravel_ram_wb_bist.sv
// tb_caravel_ram_wb_bist: directed bench for caravel_ram_wb_bist.
// Two instances: a 16-word one for most scenarios and a full-size one for
// the LFSR stuck-bit scenario. Each has its own behavioural RAM slave.
module tb_caravel_ram_wb_bist;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pattern_sel = '0;
  logic [31:0] seed = '0;
  logic        start_s = 1'b0;
  logic        start_f = 1'b0;

  logic        cyc_s, stb_s, we_s, ack_s, busy_s, done_s, pass_s, to_s;
  logic [3:0]  sel_s;
  logic [31:0] adr_s, dat_s, rdat_s, fdata_s;
  logic [15:0] err_s;
  logic [12:0] fidx_s;

  logic        cyc_f, stb_f, we_f, ack_f, busy_f, done_f, pass_f, to_f;
  logic [3:0]  sel_f;
  logic [31:0] adr_f, dat_f, rdat_f, fdata_f;
  logic [15:0] err_f;
  logic [12:0] fidx_f;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  caravel_ram_wb_bist #(.WORDS(16), .TIMEOUT(255)) dut_s (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_s),
    .pattern_sel_i(pattern_sel), .seed_i(seed),
    .wbm_cyc_o(cyc_s), .wbm_stb_o(stb_s), .wbm_we_o(we_s), .wbm_sel_o(sel_s),
    .wbm_adr_o(adr_s), .wbm_dat_o(dat_s), .wbm_ack_i(ack_s), .wbm_dat_i(rdat_s),
    .busy_o(busy_s), .done_o(done_s), .pass_o(pass_s), .timeout_o(to_s),
    .err_count_o(err_s), .fail_idx_o(fidx_s), .fail_data_o(fdata_s)
  );

  caravel_ram_wb_bist dut_f (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_f),
    .pattern_sel_i(pattern_sel), .seed_i(seed),
    .wbm_cyc_o(cyc_f), .wbm_stb_o(stb_f), .wbm_we_o(we_f), .wbm_sel_o(sel_f),
    .wbm_adr_o(adr_f), .wbm_dat_o(dat_f), .wbm_ack_i(ack_f), .wbm_dat_i(rdat_f),
    .busy_o(busy_f), .done_o(done_f), .pass_o(pass_f), .timeout_o(to_f),
    .err_count_o(err_f), .fail_idx_o(fidx_f), .fail_data_o(fdata_f)
  );

  // ---------------- small-instance RAM slave ----------------
  logic [31:0] mem_s [0:15];
  logic        waited_s;
  logic        zero_wait = 1'b0;
  int          hang_idx = -1;
  int          cor_a = -1, cor_b = -1;
  logic [31:0] off_s;
  logic [12:0] ia_s;

  always_comb begin
    off_s  = adr_s - BASE;
    ia_s   = off_s[14:2];
    ack_s  = cyc_s && stb_s && (zero_wait || waited_s) &&
             !(we_s && int'(ia_s) == hang_idx);
    rdat_s = mem_s[ia_s[3:0]];
    if (int'(ia_s) == cor_a || int'(ia_s) == cor_b) rdat_s = rdat_s ^ 32'h1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waited_s <= 1'b0;
    else begin
      waited_s <= cyc_s && stb_s && !ack_s;
      if (ack_s && we_s) mem_s[ia_s[3:0]] <= dat_s;
    end
  end

  // ---------------- full-instance RAM slave (1 wait, bit 5 stuck-at-1 at 100) ----
  logic [31:0] mem_f [0:6143];
  logic        waited_f;
  logic [31:0] off_f;
  logic [12:0] ia_f;

  always_comb begin
    off_f  = adr_f - BASE;
    ia_f   = off_f[14:2];
    ack_f  = cyc_f && stb_f && waited_f;
    rdat_f = (ia_f < 13'd6144) ? mem_f[ia_f] : 32'h0;
    if (ia_f == 13'd100) rdat_f = rdat_f | 32'h20;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waited_f <= 1'b0;
    else begin
      waited_f <= cyc_f && stb_f && !ack_f;
      if (ack_f && we_f && ia_f < 13'd6144) mem_f[ia_f] <= dat_f;
    end
  end

  // ---------------- small-instance bus monitor ----------------
  int unsigned wcnt = 0, w0cnt = 0, stb3 = 0;
  logic [31:0] wadr [0:63];
  logic [31:0] wdat [0:63];

  always @(posedge clk) begin
    if (cyc_s && stb_s && we_s && ack_s) begin
      wadr[wcnt % 64] <= adr_s;
      wdat[wcnt % 64] <= dat_s;
      wcnt <= wcnt + 1;
      if (adr_s == BASE) w0cnt <= w0cnt + 1;
    end
    if (cyc_s && stb_s && we_s && adr_s == BASE + 32'd12) stb3 <= stb3 + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_s(input string tag);
    check({tag, " cyc"}, {31'b0, cyc_s}, 32'h0);
    check({tag, " stb"}, {31'b0, stb_s}, 32'h0);
    check({tag, " we"}, {31'b0, we_s}, 32'h0);
    check({tag, " sel"}, {28'b0, sel_s}, 32'h0);
    check({tag, " adr"}, adr_s, 32'h0);
    check({tag, " dat"}, dat_s, 32'h0);
    check({tag, " busy"}, {31'b0, busy_s}, 32'h0);
    check({tag, " done"}, {31'b0, done_s}, 32'h0);
    check({tag, " pass"}, {31'b0, pass_s}, 32'h0);
    check({tag, " timeout"}, {31'b0, to_s}, 32'h0);
    check({tag, " err"}, {16'b0, err_s}, 32'h0);
    check({tag, " fidx"}, {19'b0, fidx_s}, 32'h0);
    check({tag, " fdata"}, fdata_s, 32'h0);
  endtask

  // Drives start for exactly one sampling edge (unless hold) and returns #1 after it.
  task automatic start_test(input bit full, input logic [1:0] ps, input logic [31:0] sd,
                            input bit hold);
    @(negedge clk);
    pattern_sel = ps;
    seed = sd;
    if (full) start_f = 1'b1; else start_s = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin start_f = 1'b0; start_s = 1'b0; end
  endtask

  // n = index of the first cycle (1 = cycle after the start edge) with done high.
  task automatic wait_done(input bit full, input string tag, input int unsigned limit,
                           output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(full ? done_f : done_s) && n < limit);
    if (!(full ? done_f : done_s)) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: done_o observed 0 expected 1 within %0d cycles", tag, limit);
    end
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] sd, input int unsigned steps);
    logic [31:0] s;
    s = (sd == 32'h0) ? 32'h1 : sd;
    for (int unsigned i = 0; i < steps; i++)
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  initial begin
    int unsigned n, wb, sb, w0b;
    logic [31:0] exp100;
    bit          mism;

    // reset state
    #12;
    check_idle_s("reset");
    check("reset_f busy", {31'b0, busy_f}, 32'h0);
    check("reset_f cyc", {31'b0, cyc_f}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_s("idle");

    // T1: pattern 0, seed 0, 1-wait slave
    wb = wcnt;
    start_test(1'b0, 2'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1 cyc first", {31'b0, cyc_s}, 32'h1);
    check("t1 busy", {31'b0, busy_s}, 32'h1);
    wait_done(1'b0, "t1 wait", 200, n);
    n = n + 1;  // first negedge already consumed above
    check("t1 done cycle", n, 32'd97);
    check("t1 pass", {31'b0, pass_s}, 32'h1);
    check("t1 err", {16'b0, err_s}, 32'h0);
    check("t1 busy end", {31'b0, busy_s}, 32'h0);
    check("t1 cyc end", {31'b0, cyc_s}, 32'h0);
    check("t1 nwrites", wcnt - wb, 32'd16);
    for (int unsigned k = 0; k < 16; k++) begin
      check($sformatf("t1 wadr[%0d]", k), wadr[(wb + k) % 64], BASE + 32'(4 * k));
      check($sformatf("t1 wdat[%0d]", k), wdat[(wb + k) % 64], 32'(k));
    end

    // T3: pattern 3, seed AAAAAAAA, corrupt 7 and 9
    cor_a = 7; cor_b = 9;
    start_test(1'b0, 2'd3, 32'hAAAA_AAAA, 1'b0);
    wait_done(1'b0, "t3 wait", 200, n);
    check("t3 err", {16'b0, err_s}, 32'd2);
    check("t3 fidx", {19'b0, fidx_s}, 32'd7);
    check("t3 fdata", fdata_s, 32'h5555_5554);
    check("t3 pass", {31'b0, pass_s}, 32'h0);
    check("t3 timeout", {31'b0, to_s}, 32'h0);
    cor_a = -1; cor_b = -1;

    // T4: no ack on write of word 3
    hang_idx = 3;
    sb = stb3;
    start_test(1'b0, 2'd0, 32'h0, 1'b0);
    wait_done(1'b0, "t4 wait", 1000, n);
    check("t4 stb cycles", stb3 - sb, 32'd255);
    check("t4 cyc", {31'b0, cyc_s}, 32'h0);
    check("t4 stb", {31'b0, stb_s}, 32'h0);
    check("t4 timeout", {31'b0, to_s}, 32'h1);
    check("t4 pass", {31'b0, pass_s}, 32'h0);
    check("t4 done", {31'b0, done_s}, 32'h1);
    check("t4 err", {16'b0, err_s}, 32'h0);
    hang_idx = -1;

    // T5: reset pulse during read pass
    start_test(1'b0, 2'd1, 32'h1234_5678, 1'b0);
    n = 0;
    while (!(stb_s && !we_s) && n < 300) begin @(negedge clk); n++; end
    check("t5 in read pass", {31'b0, stb_s && !we_s}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_s("t5 reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_test(1'b0, 2'd1, 32'h1234_5678, 1'b0);
    wait_done(1'b0, "t5 wait", 200, n);
    check("t5 pass", {31'b0, pass_s}, 32'h1);
    check("t5 timeout", {31'b0, to_s}, 32'h0);
    check("t5 err", {16'b0, err_s}, 32'h0);

    // T6: start held high, zero-wait slave
    zero_wait = 1'b1;
    w0b = w0cnt;
    start_test(1'b0, 2'd0, 32'h0000_00F0, 1'b1);
    wait_done(1'b0, "t6 wait", 200, n);
    check("t6 done cycle", n, 32'd65);
    check("t6 single run", w0cnt - w0b, 32'd1);
    check("t6 pass", {31'b0, pass_s}, 32'h1);
    @(negedge clk);
    check("t6 restart busy", {31'b0, busy_s}, 32'h1);
    check("t6 restart done", {31'b0, done_s}, 32'h0);
    start_s = 1'b0;
    wait_done(1'b0, "t6 wait2", 200, n);
    check("t6 pass2", {31'b0, pass_s}, 32'h1);
    zero_wait = 1'b0;

    // T2: full size, LFSR, bit 5 stuck-at-1 at index 100
    exp100 = lfsr_model(32'hDEAD_BEEF, 100);
    mism = !exp100[5];
    start_test(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0);
    wait_done(1'b1, "t2 wait", 40000, n);
    check("t2 done cycle", n, 32'd36865);
    check("t2 err", {16'b0, err_f}, mism ? 32'd1 : 32'd0);
    check("t2 fidx", {19'b0, fidx_f}, mism ? 32'd100 : 32'd0);
    check("t2 fdata", fdata_f, mism ? (exp100 | 32'h20) : 32'h0);
    check("t2 pass", {31'b0, pass_f}, mism ? 32'h0 : 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
